// File: rtl/fft_sample_decimator.sv
// Accumulate-and-dump decimator feeding the FFT input FIFO.
// Pads with zero words so the FIFO only ever receives whole frames.
module fft_sample_decimator #(
   parameter int DIN_W      = 16,
   parameter int DOUT_W     = 22,
   parameter int LOG2_DECIM = 2,
   parameter int FRAME_LEN  = 64
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              en,
   input  logic              s_valid,
   input  logic [DIN_W-1:0]  s_data,
   output logic              s_ready,
   output logic              wr_en,
   output logic [DOUT_W-1:0] dout,
   input  logic              full,
   output logic              frame_done,
   output logic [15:0]       drop_cnt,
   output logic              busy
);

   localparam int AW = DIN_W + LOG2_DECIM;
   localparam int CW = $clog2(FRAME_LEN);
   localparam logic [LOG2_DECIM-1:0] PH_MAX = '1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_LEN - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAD} state_t;

   state_t                 state_q, state_d;
   logic signed [AW-1:0]   acc_q, acc_d;
   logic signed [AW-1:0]   sum;
   logic signed [DIN_W-1:0] s_sgn;
   logic [LOG2_DECIM-1:0]  phase_q, phase_d;
   logic                   out_vld_q, out_vld_d;
   logic [DOUT_W-1:0]      dout_q, dout_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [15:0]            drop_q, drop_d;
   logic                   accept;
   logic                   vld_left;

   assign s_sgn = s_data;
   assign sum   = acc_q + AW'(s_sgn);

   assign wr_en      = out_vld_q & ~full;
   assign frame_done = wr_en & (cnt_q == CNT_MAX);
   assign busy       = (state_q != IDLE);
   assign dout       = dout_q;
   assign drop_cnt   = drop_q;

   assign s_ready = (state_q == RUN) & en &
                    (~out_vld_q | ~full | (phase_q != PH_MAX));
   assign accept  = s_valid & s_ready;

   // Output-register occupancy and frame position after this cycle's write
   assign vld_left = out_vld_q & ~wr_en;
   assign cnt_d    = !wr_en ? cnt_q :
                     (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);

   assign drop_d = (en & s_valid & ~s_ready & (drop_q != 16'hFFFF)) ?
                   drop_q + 16'd1 : drop_q;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      phase_d   = phase_q;
      out_vld_d = vld_left;
      dout_d    = dout_q;
      unique case (state_q)
         IDLE: begin
            acc_d   = '0;
            phase_d = '0;
            if (en) state_d = RUN;
         end
         RUN: begin
            if (!en) begin
               acc_d   = '0;
               phase_d = '0;
               state_d = (cnt_d == '0 && !vld_left) ? IDLE : PAD;
            end else if (accept) begin
               if (phase_q == PH_MAX) begin
                  dout_d    = DOUT_W'(sum);
                  out_vld_d = 1'b1;
                  acc_d     = '0;
                  phase_d   = '0;
               end else begin
                  acc_d   = sum;
                  phase_d = phase_q + LOG2_DECIM'(1);
               end
            end
         end
         PAD: begin
            if (!vld_left) begin
               if (cnt_d == '0) begin
                  state_d = IDLE;
               end else begin
                  dout_d    = '0;
                  out_vld_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         phase_q   <= '0;
         out_vld_q <= 1'b0;
         dout_q    <= '0;
         cnt_q     <= '0;
         drop_q    <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         phase_q   <= phase_d;
         out_vld_q <= out_vld_d;
         dout_q    <= dout_d;
         cnt_q     <= cnt_d;
         drop_q    <= drop_d;
      end
   end

endmodule
